// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default widths and the architectural zero-register index.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_W_DEF = 5;
   localparam int unsigned CNT_W_DEF = 32;

   // Writes to register 0 are discarded, so it can never create a dependency
   localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage : pipeline_hazard_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use / mispredict detection with priority resolution.
// Ports:
//   en_i                 - hazard outputs enabled (pipeline running, not in reset)
//   id_rs_i, id_rt_i     - ID-stage source registers
//   id_use_rs_i/_rt_i    - ID instruction reads rs / rt
//   ex_mem_read_i        - EX instruction is a load
//   ex_rd_i              - EX load destination
//   ex_br_valid_i/_taken_i, ex_predict_bs_i - EX branch resolution and prediction
//   bubble_o, clear_if_id_o, clear_id_ex_o, redirect_o - pipeline control
//   stall_o, flush_o     - one-cycle event strobes for the statistics counters
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF
) (
   input  logic             en_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_br_valid_i,
   input  logic             ex_br_taken_i,
   input  logic             ex_predict_bs_i,
   output logic             bubble_o,
   output logic             clear_if_id_o,
   output logic             clear_id_ex_o,
   output logic             redirect_o,
   output logic             stall_o,
   output logic             flush_o
);

   logic luh;
   logic mp;

   // Mispredict wins: the ID instruction is on the wrong path, so stalling it is pointless
   always_comb begin
      luh           = 1'b0;
      mp            = 1'b0;
      bubble_o      = 1'b0;
      clear_if_id_o = 1'b0;
      clear_id_ex_o = 1'b0;
      redirect_o    = 1'b0;
      stall_o       = 1'b0;
      flush_o       = 1'b0;

      luh = ex_mem_read_i && (ex_rd_i != REG_W'(ZERO_REG)) &&
            ((id_use_rs_i && (id_rs_i == ex_rd_i)) ||
             (id_use_rt_i && (id_rt_i == ex_rd_i)));
      mp  = ex_br_valid_i && (ex_br_taken_i != ex_predict_bs_i);

      if (en_i) begin
         if (mp) begin
            clear_if_id_o = 1'b1;
            clear_id_ex_o = 1'b1;
            redirect_o    = 1'b1;
            flush_o       = 1'b1;
         end else if (luh) begin
            bubble_o      = 1'b1;
            clear_id_ex_o = 1'b1;
            stall_o       = 1'b1;
         end
      end
   end

endmodule : pipeline_hazard_ctrl_hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: RUN/HALT FSM with resume-button edge detect,
// hazard-driven bubble/flush/redirect control and statistics counters.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   go                  - resume button (level, already synchronised)
//   halt_req            - syscall halt in WB
//   id_*/ex_*           - hazard detection inputs (see hazard_detect)
//   run, halted         - global pipeline enable / FSM in HALT
//   bubble_if_id, clear_if_id, clear_id_ex, redirect - same-cycle hazard control
//   cycle_cnt, stall_cnt, flush_cnt - RUN cycles, load-use stalls, mispredict flushes
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             halt_req,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_br_valid,
   input  logic             ex_br_taken,
   input  logic             ex_predict_bs,
   output logic             run,
   output logic             bubble_if_id,
   output logic             clear_if_id,
   output logic             clear_id_ex,
   output logic             redirect,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e           state_q, state_d;
   logic             go_q;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             hz_en;
   logic             stall_ev;
   logic             flush_ev;

   // run/halted decode directly from the state flop
   assign run    = (state_q == ST_RUN);
   assign halted = (state_q == ST_HALT);

   // Hazard outputs are forced low while reset is asserted
   assign hz_en = run && rst_n;

   pipeline_hazard_ctrl_hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .en_i            (hz_en),
      .id_rs_i         (id_rs),
      .id_rt_i         (id_rt),
      .id_use_rs_i     (id_use_rs),
      .id_use_rt_i     (id_use_rt),
      .ex_mem_read_i   (ex_mem_read),
      .ex_rd_i         (ex_rd),
      .ex_br_valid_i   (ex_br_valid),
      .ex_br_taken_i   (ex_br_taken),
      .ex_predict_bs_i (ex_predict_bs),
      .bubble_o        (bubble_if_id),
      .clear_if_id_o   (clear_if_id),
      .clear_id_ex_o   (clear_id_ex),
      .redirect_o      (redirect),
      .stall_o         (stall_ev),
      .flush_o         (flush_ev)
   );

   // State, go history and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         go_q    <= 1'b0;
         cycle_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         go_q    <= go;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Next state; only a fresh go edge resumes, so a held button fires once
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:  if (halt_req)     state_d = ST_HALT;
         ST_HALT: if (go && !go_q)  state_d = ST_RUN;
      endcase
   end

   // Counters freeze outside RUN; event strobes are already gated by run
   always_comb begin
      cycle_d = cycle_q;
      stall_d = stall_q + CNT_W'(stall_ev);
      flush_d = flush_q + CNT_W'(flush_ev);
      if (run) cycle_d = cycle_q + CNT_W'(1);
   end

   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario-based bench for pipeline_hazard_ctrl with an expected-hazard queue
// and a behavioural model of the FSM and counters.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             go, halt_req;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             id_use_rs, id_use_rt, ex_mem_read;
   logic             ex_br_valid, ex_br_taken, ex_predict_bs;
   logic             run, bubble_if_id, clear_if_id, clear_id_ex, redirect, halted;
   logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

   typedef struct packed {
      logic bub;
      logic cif;
      logic cex;
      logic red;
   } haz_t;

   haz_t             exp_q[$];
   logic             m_run, m_gq;
   logic [CNT_W-1:0] m_cyc, m_stall, m_flush;
   int               n_checks = 0;
   int               n_pass   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .go            (go),
      .halt_req      (halt_req),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_use_rs     (id_use_rs),
      .id_use_rt     (id_use_rt),
      .ex_mem_read   (ex_mem_read),
      .ex_rd         (ex_rd),
      .ex_br_valid   (ex_br_valid),
      .ex_br_taken   (ex_br_taken),
      .ex_predict_bs (ex_predict_bs),
      .run           (run),
      .bubble_if_id  (bubble_if_id),
      .clear_if_id   (clear_if_id),
      .clear_id_ex   (clear_id_ex),
      .redirect      (redirect),
      .halted        (halted),
      .cycle_cnt     (cycle_cnt),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   function automatic logic model_luh();
      return ex_mem_read && (ex_rd != '0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
   endfunction

   function automatic logic model_mp();
      return ex_br_valid && (ex_br_taken != ex_predict_bs);
   endfunction

   task automatic model_reset();
      m_run   = 1'b1;
      m_gq    = 1'b0;
      m_cyc   = '0;
      m_stall = '0;
      m_flush = '0;
      exp_q.delete();
   endtask

   // Apply one cycle of inputs and queue the expected hazard outputs
   task automatic drive(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic urs, input logic urt, input logic mr,
                        input logic [REG_W-1:0] rd, input logic bv, input logic bt,
                        input logic bp, input logic hr, input logic g);
      haz_t e;
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_mem_read = mr; ex_rd = rd; ex_br_valid = bv; ex_br_taken = bt;
      ex_predict_bs = bp; halt_req = hr; go = g;
      e = '0;
      if (m_run && rst_n) begin
         if (model_mp())       e = '{bub: 1'b0, cif: 1'b1, cex: 1'b1, red: 1'b1};
         else if (model_luh()) e = '{bub: 1'b1, cif: 1'b0, cex: 1'b1, red: 1'b0};
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic hr, input logic g);
      drive('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, hr, g);
   endtask

   // Mid-cycle sample of the hazard outputs together with the queued expectation
   task automatic sample(output haz_t got, output haz_t exp, output bit ok);
      @(negedge clk);
      got = '{bub: bubble_if_id, cif: clear_if_id, cex: clear_id_ex, red: redirect};
      ok  = (exp_q.size() != 0);
      exp = ok ? exp_q.pop_front() : '0;
   endtask

   // Clock edge: advance the model with the inputs that were just sampled
   task automatic tick();
      @(posedge clk);
      if (m_run) begin
         m_cyc = m_cyc + 1;
         if (model_mp())       m_flush = m_flush + 1;
         else if (model_luh()) m_stall = m_stall + 1;
      end
      if (m_run && halt_req)           m_run = 1'b0;
      else if (!m_run && go && !m_gq)  m_run = 1'b1;
      m_gq = go;
      #1;
   endtask

   task automatic test_reset();
      haz_t got, exp; bit ok;
      model_reset();
      rst_n = 1'b0;
      drive(5'd8, '0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      n_checks++;
      if ({run, halted} !== 2'b10) $display("FAIL reset_state run/halted=%b want 10", {run, halted});
      else n_pass++;
      n_checks++;
      if ({cycle_cnt, stall_cnt, flush_cnt} !== '0)
         $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", cycle_cnt, stall_cnt, flush_cnt);
      else n_pass++;
      sample(got, exp, ok);
      n_checks++;
      if (!ok || got !== exp || got !== 4'b0000) $display("FAIL reset_haz got=%b want=%b", got, exp);
      else n_pass++;
      #2;
      rst_n = 1'b1;
      id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_rd = '0;
      ex_br_valid = 0; ex_br_taken = 0; ex_predict_bs = 0; halt_req = 0; go = 0;
      tick();
      n_checks++;
      if (cycle_cnt !== m_cyc) $display("FAIL first_cycle cycle_cnt=%0d want %0d", cycle_cnt, m_cyc);
      else n_pass++;
   endtask

   task automatic test_load_use();
      haz_t got, exp; bit ok;
      drive(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample(got, exp, ok);
      n_checks++;
      if (!ok || got !== exp || got !== 4'b1010) $display("FAIL load_use_haz got=%b want=%b", got, exp);
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cnt !== m_stall || stall_cnt !== 32'd1)
         $display("FAIL load_use_stall stall_cnt=%0d want %0d", stall_cnt, m_stall);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      haz_t got, exp; bit ok;
      drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample(got, exp, ok);
      n_checks++;
      if (!ok || got !== exp || got !== 4'b0000) $display("FAIL zero_reg_haz got=%b want=%b", got, exp);
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cnt !== m_stall) $display("FAIL zero_reg_stall stall_cnt=%0d want %0d", stall_cnt, m_stall);
      else n_pass++;
   endtask

   task automatic test_mispredict();
      haz_t got, exp; bit ok;
      drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      sample(got, exp, ok);
      n_checks++;
      if (!ok || got !== exp || got !== 4'b0111) $display("FAIL mp_luh_haz got=%b want=%b", got, exp);
      else n_pass++;
      tick();
      n_checks++;
      if (flush_cnt !== m_flush || stall_cnt !== m_stall)
         $display("FAIL mp_luh_cnt flush/stall=%0d/%0d want %0d/%0d", flush_cnt, stall_cnt, m_flush, m_stall);
      else n_pass++;
   endtask

   task automatic test_random();
      haz_t got, exp; bit ok;
      for (int i = 0; i < 24; i++) begin
         drive(REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), REG_W'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
         sample(got, exp, ok);
         n_checks++;
         if (!ok || got !== exp) $display("FAIL rand_haz[%0d] got=%b want=%b", i, got, exp);
         else n_pass++;
         tick();
         n_checks++;
         if ({cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush})
            $display("FAIL rand_cnt[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i,
                     cycle_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
         else n_pass++;
      end
   endtask

   task automatic test_halt_resume();
      haz_t got, exp; bit ok;
      logic [CNT_W-1:0] frozen;
      idle(1'b1, 1'b0);
      sample(got, exp, ok);
      tick();
      n_checks++;
      if ({run, halted} !== 2'b01 || m_run !== 1'b0) $display("FAIL halt_enter run/halted=%b want 01", {run, halted});
      else n_pass++;
      frozen = cycle_cnt;
      for (int i = 0; i < 10; i++) begin
         drive(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         sample(got, exp, ok);
         n_checks++;
         if (!ok || got !== exp || got !== 4'b0000) $display("FAIL halt_haz[%0d] got=%b want=%b", i, got, exp);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (cycle_cnt !== frozen || {cycle_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush})
         $display("FAIL halt_frozen cycle_cnt=%0d want %0d", cycle_cnt, frozen);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         idle(1'b0, 1'b1);
         sample(got, exp, ok);
         tick();
         n_checks++;
         if ({run, halted} !== {m_run, ~m_run} || run !== 1'b1)
            $display("FAIL go_held[%0d] run/halted=%b want %b", i, {run, halted}, {m_run, ~m_run});
         else n_pass++;
      end
      idle(1'b0, 1'b0); sample(got, exp, ok); tick();
      idle(1'b0, 1'b1); sample(got, exp, ok); tick();
      idle(1'b0, 1'b0); sample(got, exp, ok); tick();
      n_checks++;
      if ({run, halted} !== 2'b10 || cycle_cnt !== m_cyc)
         $display("FAIL go_in_run run/halted=%b cycle_cnt=%0d want 10/%0d", {run, halted}, cycle_cnt, m_cyc);
      else n_pass++;
   endtask

   task automatic test_halt_hazard();
      haz_t got, exp; bit ok;
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      sample(got, exp, ok);
      n_checks++;
      if (!ok || got !== exp || got !== 4'b0111) $display("FAIL halt_mp_haz got=%b want=%b", got, exp);
      else n_pass++;
      tick();
      n_checks++;
      if (flush_cnt !== m_flush || {run, halted} !== 2'b01)
         $display("FAIL halt_mp_after flush_cnt=%0d run/halted=%b want %0d/01", flush_cnt, {run, halted}, m_flush);
      else n_pass++;
      idle(1'b0, 1'b1); sample(got, exp, ok); tick();
      idle(1'b0, 1'b0); sample(got, exp, ok); tick();
      n_checks++;
      if (run !== 1'b1 || cycle_cnt !== m_cyc) $display("FAIL halt_mp_resume run=%b want 1", run);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      haz_t got, exp; bit ok;
      idle(1'b1, 1'b0); sample(got, exp, ok); tick();
      idle(1'b0, 1'b0); sample(got, exp, ok);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({run, halted} !== 2'b10 || {cycle_cnt, stall_cnt, flush_cnt} !== '0)
         $display("FAIL async_rst run/halted=%b cnt=%0d/%0d/%0d want 10/0/0/0",
                  {run, halted}, cycle_cnt, stall_cnt, flush_cnt);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({run, halted} !== 2'b10 || cycle_cnt !== '0)
         $display("FAIL async_release run/halted=%b cycle_cnt=%0d want 10/0", {run, halted}, cycle_cnt);
      else n_pass++;
      model_reset();
      tick();
      n_checks++;
      if (cycle_cnt !== m_cyc || cycle_cnt !== 32'd1) $display("FAIL post_rst_cycle cycle_cnt=%0d want 1", cycle_cnt);
      else n_pass++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_mispredict();
      test_random();
      test_halt_resume();
      test_halt_hazard();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces the global run enable, the IF/ID bubble (hold), and the per-stage clear (flush) signals.
- Detects load-use hazards and branch mispredicts; runs a RUN/HALT state machine driven by syscall halt and the resume button.
- Keeps cycle, stall and flush statistics counters for the board display.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- go  in  1  resume button, level input, synchronised upstream.
- halt_req  in  1  syscall-halt instruction valid in WB.
- id_rs  in  REG_W  ID-stage source register 1.
- id_rt  in  REG_W  ID-stage source register 2.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_W  EX load destination register.
- ex_br_valid  in  1  EX holds a resolved branch/jump.
- ex_br_taken  in  1  actual branch outcome.
- ex_predict_bs  in  1  prediction bit carried down the pipe.
- run  out  1  global pipeline-register enable.
- bubble_if_id  out  1  hold IF/ID and PC.
- clear_if_id  out  1  flush IF/ID.
- clear_id_ex  out  1  flush ID/EX.
- redirect  out  1  PC selects the corrected target.
- halted  out  1  FSM in HALT.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  mispredict flushes.

Behaviour:
- Reset (async, rst_n=0): state=RUN, run=1, halted=0, all counters=0, go_q=0. Hazard outputs are 0 during reset.
- FSM states:
  - RUN (run=1).
  - HALT (run=0, halted=1).
- FSM transitions:
  - RUN->HALT: halt_req=1 sampled at edge N; run=0 from cycle N+1.
  - HALT->RUN: rising edge of go (go=1 & go_q=0), registered; run=1 the next cycle.
  - go_q <= go every cycle. A held go does not retrigger. A go edge while in RUN is ignored.
- Load-use hazard (combinational):
  - luh = ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Mispredict (combinational):
  - mp = ex_br_valid & (ex_br_taken != ex_predict_bs).
- Outputs, all gated by run (all 0 when run=0):
  - mp=1: clear_if_id=1, clear_id_ex=1, redirect=1, bubble_if_id=0.
  - else luh=1: bubble_if_id=1, clear_id_ex=1.
  - else: all 0.
- Priority: mispredict over load-use, because the ID instruction is wrong-path.
- Latency: hazard outputs are valid in the same cycle as their inputs. Pipeline registers act at the next edge.
- Counters (registered, wrap modulo 2^CNT_W, frozen while run=0):
  - cycle_cnt += 1 each RUN cycle.
  - stall_cnt += 1 when luh & ~mp.
  - flush_cnt += 1 when mp.
- Simultaneous halt_req with mp or luh: the hazard outputs and counters for that cycle still take effect (run=1 that cycle); HALT begins next cycle.
- Reset asserted mid-HALT or mid-stall: immediate return to RUN, counters cleared.

Decomposition:
- Shared package:
  - state encoding (ST_RUN, ST_HALT);
  - REG_W and CNT_W defaults;
  - zero-register constant.
- One sub-module, hazard_detect: purely combinational luh/mp computation plus priority resolution.
- Top module: FSM, go edge detect, counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for 1 cycle -> bubble_if_id=1, clear_id_ex=1, clear_if_id=0; stall_cnt 0->1.
- Register-zero exemption: same stimulus with ex_rd=0 -> all hazard outputs 0; stall_cnt unchanged.
- Mispredict with load-use in the same cycle: ex_br_valid=1, ex_br_taken=1, ex_predict_bs=0, plus luh -> clear_if_id=1, clear_id_ex=1, redirect=1, bubble_if_id=0; flush_cnt +1, stall_cnt unchanged.
- Halt and resume:
  - halt_req pulse -> run=0 and halted=1 next cycle; cycle_cnt frozen for 10 cycles.
  - go held high 5 cycles -> exactly one resume, run=1 one cycle after the go edge.
- Halt with hazard: halt_req and mp in the same cycle -> flush outputs asserted that cycle, flush_cnt +1, then HALT.
- Async reset mid-HALT (rst_n low between edges) -> run=1, halted=0, counters=0 immediately; no change on release until the next clk edge.
